inst_mem_sync: RTL and testbench
================================

# inst_mem_sync

Parametrised, synchronous successor to the pipeline's combinational instruction ROM. Serves fetch requests over a valid/ready request channel and a valid/ready response channel with one-cycle latency and full throughput. Adds misalignment/range error reporting, a pipeline flush, a byte-enabled loader write port for program download, and a saturating error counter. Sits between the IF stage and the program-memory array.

## Interface
- DATA_W, 32, instruction word width in bits; multiple of 8, power of two.
- DEPTH, 1024, number of words; power of two.
- ADDR_W, 32, byte-address width.
- ERRCNT_W, 16, error counter width.
- clk  in  1  clock; all state updates on its rising edge.
- arst_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  fetch request valid.
- req_ready_o  out  1  fetch request accepted this cycle when high together with req_valid_i.
- req_addr_i  in  ADDR_W  fetch byte address.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_data_o  out  DATA_W  fetched word.
- rsp_err_o  out  1  request was misaligned or out of range.
- flush_i  in  1  discard the held response; block new requests this cycle.
- ld_en_i  in  1  loader write strobe.
- ld_addr_i  in  ADDR_W  loader byte address (word-aligned; low bits ignored).
- ld_data_i  in  DATA_W  loader write data.
- ld_be_i  in  DATA_W/8  loader byte enables.
- err_cnt_o  out  ERRCNT_W  saturating count of error responses issued.

## Operation
- OFF = log2(DATA_W/8); word index = req_addr_i[OFF+log2(DEPTH)-1 : OFF].
- Misaligned: req_addr_i[OFF-1:0] != 0. Out of range: req_addr_i >= DEPTH*(DATA_W/8). Either sets rsp_err_o = 1 and rsp_data_o = 0; the array is not read.
- req_ready_o = !ld_en_i && !flush_i && (!rsp_valid_o || rsp_ready_i). This is combinational, with no registered path from req_valid_i.
- The output register holds exactly one response. A response is kept stable (data and err) while rsp_valid_o && !rsp_ready_i.
- Accept (req_valid_i && req_ready_o) in cycle N loads the output register. rsp_valid_o = 1 in cycle N+1.
- When rsp_ready_i is high with no new accept, rsp_valid_o falls the next cycle.
- Flush: flush_i in cycle N forces rsp_valid_o = 0 in N+1 regardless of rsp_ready_i. No accept occurs in N. rsp_data_o/rsp_err_o keep their values and are meaningless while rsp_valid_o = 0.
- Loader: ld_en_i in cycle N writes the bytes of ld_data_i enabled by ld_be_i to word ld_addr_i[OFF+log2(DEPTH)-1:OFF]. The write takes effect at the end of N.
  - Out-of-range loader addresses are dropped silently.
  - ld_en_i blocks fetch acceptance in N; a held response is unaffected.
- err_cnt_o increments by 1 on every accepted request flagged as an error. It saturates at 2^ERRCNT_W-1.
- The memory array is not reset. Contents survive arst_n and change only through the loader.

## Timing
- Reset (arst_n = 0 at a rising edge): rsp_valid_o = 0, rsp_data_o = 0, rsp_err_o = 0, err_cnt_o = 0.
  - req_ready_o evaluates to 1 while in reset provided ld_en_i = 0 and flush_i = 0. Accepts during reset are discarded.
  - Reset mid-operation drops any held response.
- Latency is 1 cycle from accept to rsp_valid_o. Throughput is 1 word/cycle with rsp_ready_i held high.
- Read-after-load: a load in cycle N followed by a fetch of the same word accepted in N+1 returns the new data in N+2.
- Simultaneous flush_i and rsp_ready_i: flush wins, and the response is treated as not consumed.
- Simultaneous flush_i and ld_en_i: both act; the write completes.
- Backpressure with a new request: req_ready_o = 0 until the held response is taken. The new request is accepted in the same cycle that rsp_ready_i = 1.

## Test plan
- Load words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193 (ld_be_i = 0xF). Fetch 0x0, 0x4, 0x8, 0xC back-to-back with rsp_ready_i = 1 -> the four words on consecutive cycles starting one cycle after the first accept, rsp_err_o = 0.
- Partial load: ld_be_i = 0x2, ld_data_i = 0x0000AB00 at 0x4, then fetch 0x4 -> 0x0010AB93.
- Fetch 0x6, then 0x1000 (DEPTH = 1024) -> rsp_err_o = 1 and rsp_data_o = 0 each time; err_cnt_o reads 2.
- Hold rsp_ready_i = 0 for 3 cycles after the fetch of 0x8 with req_valid_i high -> rsp_data_o stays 0x00200113 and req_ready_o = 0. Release -> the next request is accepted that cycle.
- Assert flush_i while a response to 0xC is held -> rsp_valid_o = 0 next cycle and no accept in the flush cycle. Then apply arst_n = 0 for 1 cycle -> all outputs zero, and fetching 0x0 afterwards still returns 0x00000013.

Source files
------------

// File: rtl/inst_mem_sync.sv
// inst_mem_sync: synchronous instruction memory with one-cycle fetch latency,
// valid/ready request and response channels, misalignment/range error
// reporting, flush, a byte-enabled loader write port and a saturating
// error counter. The storage array is never reset; only the loader changes it.
module inst_mem_sync #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ERRCNT_W = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_addr_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic                  rsp_err_o,
  input  logic                  flush_i,
  input  logic                  ld_en_i,
  input  logic [ADDR_W-1:0]     ld_addr_i,
  input  logic [DATA_W-1:0]     ld_data_i,
  input  logic [DATA_W/8-1:0]   ld_be_i,
  output logic [ERRCNT_W-1:0]   err_cnt_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF   = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  // First byte address past the end of the array, one bit wider than the
  // address so the comparison cannot wrap.
  localparam logic [ADDR_W:0]     ADDR_LIMIT = (ADDR_W + 1)'(DEPTH * NB);
  // Byte-offset bits inside a word; written as a mask so DATA_W = 8 works.
  localparam logic [ADDR_W-1:0]   OFF_MASK   = ADDR_W'(NB - 1);
  localparam logic [ERRCNT_W-1:0] CNT_MAX    = {ERRCNT_W{1'b1}};
  localparam logic [ERRCNT_W-1:0] CNT_ONE    = {{(ERRCNT_W - 1){1'b0}}, 1'b1};

  // Storage array (deliberately no reset).
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Output register and counter state.
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
  logic                rsp_err_q,   rsp_err_d;
  logic [ERRCNT_W-1:0] err_cnt_q,   err_cnt_d;

  // Request decode.
  logic              req_ready_s;
  logic              accept_s;
  logic              req_misal_s;
  logic              req_oor_s;
  logic              req_err_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic [DATA_W-1:0] rd_word_s;

  // Loader decode.
  logic              ld_oor_s;
  logic [IDX_W-1:0]  ld_idx_s;

  assign req_idx_s   = req_addr_i[OFF+IDX_W-1:OFF];
  assign req_misal_s = |(req_addr_i & OFF_MASK);
  assign req_oor_s   = ({1'b0, req_addr_i} >= ADDR_LIMIT);
  assign req_err_s   = req_misal_s | req_oor_s;
  assign rd_word_s   = mem_q[req_idx_s];

  assign ld_idx_s    = ld_addr_i[OFF+IDX_W-1:OFF];
  assign ld_oor_s    = ({1'b0, ld_addr_i} >= ADDR_LIMIT);

  // A new request fits when the output register is empty or being drained;
  // loader writes and flushes take the cycle away from fetch.
  assign req_ready_s = !ld_en_i && !flush_i && (!rsp_valid_q || rsp_ready_i);
  assign accept_s    = req_valid_i && req_ready_s;

  // Next-state logic for the response register and the error counter.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;

    // Flush overrides consumption; accept cannot happen while flushing.
    if (flush_i) begin
      rsp_valid_d = 1'b0;
    end else if (accept_s) begin
      rsp_valid_d = 1'b1;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end

    // Erroneous requests never read the array and return zero data.
    if (accept_s) begin
      rsp_err_d = req_err_s;
      if (req_err_s) begin
        rsp_data_d = {DATA_W{1'b0}};
      end else begin
        rsp_data_d = rd_word_s;
      end
    end else begin
      rsp_err_d  = rsp_err_q;
      rsp_data_d = rsp_data_q;
    end

    // Count accepted error responses, saturating at the top value.
    if (accept_s && req_err_s && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Response register and error counter, synchronously cleared by arst_n.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= {ERRCNT_W{1'b0}};
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Byte-enabled loader writes; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (ld_en_i && !ld_oor_s) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (ld_be_i[b]) begin
          mem_q[ld_idx_s][b*8 +: 8] <= ld_data_i[b*8 +: 8];
        end
      end
    end
  end

  assign req_ready_o = req_ready_s;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Self-checking bench for inst_mem_sync: a vector table of loads and fetches
// plus hand-written sequences for backpressure, flush and reset. Expected
// responses are queued when a request is accepted and compared when the
// response is presented.
module tb_inst_mem_sync;

  logic        clk;
  logic        arst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        flush_i;
  logic        ld_en_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_data_i;
  logic [3:0]  ld_be_i;
  logic [15:0] err_cnt_o;

  inst_mem_sync dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .flush_i     (flush_i),
    .ld_en_i     (ld_en_i),
    .ld_addr_i   (ld_addr_i),
    .ld_data_i   (ld_data_i),
    .ld_be_i     (ld_be_i),
    .err_cnt_o   (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        ld;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[10];
  int          n_pass;
  int          n_total;
  int          err_model;
  logic [31:0] pend_data;
  logic        pend_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Sample at the falling edge: scoreboard compare, then enqueue any accept.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (!arst_n) begin
      exp_q.delete();
      err_model = 0;
    end else begin
      chk("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, exp_q.size() != 0});
      chk("req_ready", {63'd0, req_ready_o},
          {63'd0, (!ld_en_i && !flush_i && (exp_q.size() == 0 || rsp_ready_i))});
      chk("err_cnt", {48'd0, err_cnt_o}, 64'(err_model));
      if (rsp_valid_o && exp_q.size() != 0) begin
        e = exp_q[0];
        chk("rsp_data", {32'd0, rsp_data_o}, {32'd0, e.data});
        chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, e.err});
        if (flush_i || rsp_ready_i) begin
          void'(exp_q.pop_front());
        end
      end
      if (req_valid_i && req_ready_o) begin
        e.err  = pend_err;
        e.data = pend_data;
        exp_q.push_back(e);
        if (pend_err) err_model++;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drive_fetch(input logic [31:0] a, input logic [31:0] d, input logic e);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    pend_data   = d;
    pend_err    = e;
  endtask

  initial begin
    n_pass = 0; n_total = 0; err_model = 0;
    arst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = 32'd0; rsp_ready_i = 1'b1;
    flush_i = 1'b0; ld_en_i = 1'b0; ld_addr_i = 32'd0; ld_data_i = 32'd0; ld_be_i = 4'h0;
    pend_data = 32'd0; pend_err = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0013, 4'hF, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h0010_0093, 4'hF, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0008, 32'h0020_0113, 4'hF, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_000C, 32'h0030_0193, 4'hF, 32'h0, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_0013, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0010_0093, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0020_0113, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'h0030_0193, 1'b0};
    vecs[8] = '{1'b1, 32'h0000_0004, 32'h0000_AB00, 4'h2, 32'h0, 1'b0};
    vecs[9] = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0010_AB93, 1'b0};

    // Reset and post-reset state.
    step();
    step();
    arst_n = 1'b1;
    sample();
    chk("reset_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("reset_data", {32'd0, rsp_data_o}, 64'd0);
    chk("reset_err", {63'd0, rsp_err_o}, 64'd0);
    chk("reset_errcnt", {48'd0, err_cnt_o}, 64'd0);
    chk("reset_ready", {63'd0, req_ready_o}, 64'd1);
    advance();

    // Table: loads and back-to-back fetches with rsp_ready held high.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].ld) begin
        req_valid_i = 1'b0;
        ld_en_i = 1'b1; ld_addr_i = vecs[i].addr; ld_data_i = vecs[i].data; ld_be_i = vecs[i].be;
      end else begin
        ld_en_i = 1'b0;
        drive_fetch(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err);
      end
      step();
    end
    ld_en_i = 1'b0;

    // Misaligned and out-of-range fetches.
    drive_fetch(32'h0000_0006, 32'h0, 1'b1);
    step();
    drive_fetch(32'h0000_1000, 32'h0, 1'b1);
    step();
    req_valid_i = 1'b0;
    step();
    sample();
    chk("errcnt_two", {48'd0, err_cnt_o}, 64'd2);
    advance();

    // Backpressure: fetch 0x8 held for three cycles with a new request waiting.
    rsp_ready_i = 1'b0;
    drive_fetch(32'h0000_0008, 32'h0020_0113, 1'b0);
    step();
    drive_fetch(32'h0000_000C, 32'h0030_0193, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("hold_data", {32'd0, rsp_data_o}, {32'd0, 32'h0020_0113});
      chk("hold_ready", {63'd0, req_ready_o}, 64'd0);
      advance();
    end
    rsp_ready_i = 1'b1;
    sample();
    chk("release_ready", {63'd0, req_ready_o}, 64'd1);
    advance();

    // Flush while the 0xC response is held, with rsp_ready also high.
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    step();
    flush_i = 1'b1;
    rsp_ready_i = 1'b1;
    drive_fetch(32'h0000_0000, 32'h0000_0013, 1'b0);
    sample();
    chk("flush_ready", {63'd0, req_ready_o}, 64'd0);
    advance();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    sample();
    chk("flush_valid", {63'd0, rsp_valid_o}, 64'd0);
    advance();

    // Reset with a held response, then fetch again from preserved memory.
    rsp_ready_i = 1'b0;
    drive_fetch(32'h0000_0000, 32'h0000_0013, 1'b0);
    step();
    req_valid_i = 1'b0;
    step();
    arst_n = 1'b0;
    step();
    arst_n = 1'b1;
    sample();
    chk("rst2_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("rst2_data", {32'd0, rsp_data_o}, 64'd0);
    chk("rst2_err", {63'd0, rsp_err_o}, 64'd0);
    chk("rst2_errcnt", {48'd0, err_cnt_o}, 64'd0);
    advance();
    rsp_ready_i = 1'b1;
    drive_fetch(32'h0000_0000, 32'h0000_0013, 1'b0);
    step();
    req_valid_i = 1'b0;
    step();
    step();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
